// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared FSM encoding and width helpers for the debug memory dump path
package debug_pkg;

    localparam int UART_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_LATCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_NEXT     = 3'd4,
        ST_DONE     = 3'd5
    } dump_state_e;

    function automatic int bytes_per_word(input int nb);
        return nb / UART_W;
    endfunction

    // Counter width for n values, never narrower than one bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - captures one memory word and steps it out MSB byte first
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [NB-1:0]     i_word,
    input  logic              i_send,
    input  logic              i_tx_ready,
    output logic [UART_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    output logic              o_last_accept
);

    localparam int BPW = bytes_per_word(NB);
    localparam int BW  = width_min1(BPW);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

    logic [NB-1:0] word_q, word_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [NB-1:0] shifted;
    logic          accept;
    logic          last_byte;

    always_comb begin
        accept     = i_send && i_tx_ready;
        last_byte  = (byte_cnt_q == LAST_BYTE);
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (i_load) begin
            word_d     = i_word;
            byte_cnt_d = '0;
        end else if (accept && !last_byte) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    // Shifting the current byte to the top keeps the select index constant.
    always_comb begin
        shifted       = word_q << {byte_cnt_q, 3'b000};
        o_tx_data     = i_send ? shifted[NB-1 -: UART_W] : '0;
        o_tx_valid    = i_send;
        o_last_accept = accept && last_byte;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule

// File: rtl/debug_mem_dump.sv
// rtl/debug_mem_dump.sv - walks data memory through the debug port and streams it to UART TX
module debug_mem_dump
    import debug_pkg::*;
#(
    parameter int NB          = 32,
    parameter int TAM         = 16,
    parameter int ADDR_STRIDE = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [NB-1:0]     i_debug_data,
    output logic [NB-1:0]     o_debug_address,
    output logic [UART_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int IW = width_min1(TAM);
    localparam logic [IW-1:0] IDX_LAST = IW'(TAM - 1);
    localparam logic [NB-1:0] STRIDE   = NB'(ADDR_STRIDE);

    dump_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          last_accept;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    idx_d   = '0;
                    state_d = ST_SET_ADDR;
                end
            end
            ST_SET_ADDR: state_d = ST_LATCH;
            ST_LATCH:    state_d = ST_SEND;
            ST_SEND: begin
                if (last_accept) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SET_ADDR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Address stays on idx through IDLE so the last word remains visible after a dump.
    assign o_debug_address = NB'(idx_q) * STRIDE;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

    debug_word_serializer #(
        .NB(NB)
    ) u_serializer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (state_q == ST_LATCH),
        .i_word        (i_debug_data),
        .i_send        (state_q == ST_SEND),
        .i_tx_ready    (i_tx_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .o_last_accept (last_accept)
    );

endmodule
